// File: rtl/fft_butterfly_sequencer_if.sv
// Butterfly issue bus: operand addresses, twiddle index and stage tag with a valid/ready handshake.
interface fft_butterfly_sequencer_if #(
    parameter int unsigned N_LOG2 = 3
);
    logic                        issue_valid;
    logic                        issue_ready;
    logic [N_LOG2-1:0]           addr_a;
    logic [N_LOG2-1:0]           addr_b;
    logic [N_LOG2-2:0]           tw_idx;
    logic [$clog2(N_LOG2)-1:0]   stage_idx;
    logic                        last_bfly;

    modport master (
        output issue_valid, addr_a, addr_b, tw_idx, stage_idx, last_bfly,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, addr_a, addr_b, tw_idx, stage_idx, last_bfly,
        output issue_ready
    );
endinterface

// File: rtl/fft_butterfly_sequencer.sv
// Radix-2 DIT FFT butterfly sequencer: issues A/B addresses and twiddle index per stage, then waits
// PIPE_LAT cycles between stages. Optional FFT_INVERSE_EN adds inverse/tw_conj for IFFT runs.
module fft_butterfly_sequencer #(
    parameter int unsigned N_LOG2   = 3,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
`ifdef FFT_INVERSE_EN
    input  logic inverse,
    output logic tw_conj,
`endif
    fft_butterfly_sequencer_if.master bfly
);

    localparam int unsigned Aw = N_LOG2;
    localparam int unsigned Kw = N_LOG2 - 1;
    localparam int unsigned Sw = $clog2(N_LOG2);
    localparam logic [Kw-1:0] KLast   = {Kw{1'b1}};
    localparam logic [Sw-1:0] SLast   = Sw'(N_LOG2 - 1);
    localparam logic [3:0]    GapLast = (PIPE_LAT == 0) ? 4'd0 : 4'(PIPE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StDone} state_e;

    state_e        state_q, state_d;
    logic [Kw-1:0] k_q, k_d;
    logic [Sw-1:0] s_q, s_d;
    logic [3:0]    gap_q, gap_d;

    logic          busy_q, busy_d, done_q, done_d, valid_q, valid_d, last_q, last_d;
    logic [Aw-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [Kw-1:0] tw_q, tw_d;
    logic [Sw-1:0] stage_q, stage_d;

    logic [Aw-1:0] k_ext, half, j_val, g_val, a_calc;
    logic          issuing;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        gap_d   = gap_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            StIssue: begin
                if (bfly.issue_ready) begin
                    if (k_q == KLast) begin
                        k_d = '0;
                        if (PIPE_LAT != 0) begin
                            state_d = StGap;
                            gap_d   = '0;
                        end else if (s_q == SLast) begin
                            state_d = StDone;
                        end else begin
                            s_d = s_q + Sw'(1);
                        end
                    end else begin
                        k_d = k_q + Kw'(1);
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d = '0;
                    if (s_q == SLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        s_d     = s_q + Sw'(1);
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                s_d     = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        k_ext    = {1'b0, k_d};
        half     = Aw'(1) << s_d;
        j_val    = k_ext & (half - Aw'(1));
        g_val    = k_ext >> s_d;
        a_calc   = ((g_val << s_d) << 1) | j_val;
        issuing  = (state_d == StIssue);
        addr_a_d = issuing ? a_calc : '0;
        addr_b_d = issuing ? (a_calc | half) : '0;
        tw_d     = issuing ? Kw'(j_val << (SLast - s_d)) : '0;
        stage_d  = s_d;
        last_d   = issuing && (k_d == KLast);
        valid_d  = issuing;
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            k_q      <= '0;
            s_q      <= '0;
            gap_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            s_q      <= s_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            stage_q  <= stage_d;
        end
    end

`ifdef FFT_INVERSE_EN
    logic tw_conj_q, tw_conj_d;

    always_comb begin
        tw_conj_d = tw_conj_q;
        if (state_q == StIdle && start) begin
            tw_conj_d = inverse;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tw_conj_q <= 1'b0;
        end else begin
            tw_conj_q <= tw_conj_d;
        end
    end

    assign tw_conj = tw_conj_q;
`endif

    assign busy             = busy_q;
    assign done             = done_q;
    assign bfly.issue_valid = valid_q;
    assign bfly.addr_a      = addr_a_q;
    assign bfly.addr_b      = addr_b_q;
    assign bfly.tw_idx      = tw_q;
    assign bfly.stage_idx   = stage_q;
    assign bfly.last_bfly   = last_q;

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Directed bench: N=8/PIPE_LAT=2 main instance plus an N=4/PIPE_LAT=0 instance.
module tb_fft_butterfly_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start0;
    logic busy, done, busy0, done0;
`ifdef FFT_INVERSE_EN
    logic inverse, tw_conj, inverse0, tw_conj0;
`endif

    fft_butterfly_sequencer_if #(.N_LOG2(3)) bus ();
    fft_butterfly_sequencer_if #(.N_LOG2(2)) bus0 ();

    fft_butterfly_sequencer #(.N_LOG2(3), .PIPE_LAT(2)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
`ifdef FFT_INVERSE_EN
        .inverse (inverse),
        .tw_conj (tw_conj),
`endif
        .bfly    (bus)
    );

    fft_butterfly_sequencer #(.N_LOG2(2), .PIPE_LAT(0)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start0),
        .busy    (busy0),
        .done    (done0),
`ifdef FFT_INVERSE_EN
        .inverse (inverse0),
        .tw_conj (tw_conj0),
`endif
        .bfly    (bus0)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_a  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] exp_b  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] exp_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    // {valid, a, b, tw, stage, last} for the N=4, PIPE_LAT=0 run
    logic [7:0] p0_exp [4] = '{8'b1_00_01_0_0_0, 8'b1_10_11_0_0_1, 8'b1_00_10_0_1_0, 8'b1_01_11_1_1_1};

    function automatic logic [10:0] exp_pl(int i);
        return {exp_a[i], exp_b[i], exp_tw[i], 2'(i / 4), ((i % 4) == 3)};
    endfunction

    // Transfer monitor for the main instance
    int          cyc = 0;
    int          first_cyc, done_cyc, done_cnt, hold_err;
    logic [10:0] xq [$];
    logic        prev_stall;
    logic [10:0] prev_pl;
    logic [10:0] pl;
    assign pl = {bus.addr_a, bus.addr_b, bus.tw_idx, bus.stage_idx, bus.last_bfly};

    always @(posedge clk) begin
        cyc++;
        if (prev_stall && (bus.issue_valid !== 1'b1 || pl !== prev_pl)) hold_err++;
        prev_stall = (bus.issue_valid === 1'b1) && (bus.issue_ready === 1'b0);
        prev_pl    = pl;
        if (bus.issue_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
        if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) xq.push_back(pl);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        first_cyc  = -1;
        done_cyc   = -1;
        done_cnt   = 0;
        hold_err   = 0;
        prev_stall = 1'b0;
        xq.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        start0 = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, bus.issue_valid, bus.last_bfly, pl} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {busy, done, bus.issue_valid, bus.last_bfly, pl});
        end
        n_cmp++;
        if ({busy0, done0, bus0.issue_valid, bus0.addr_a, bus0.addr_b} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_outputs_n4: got %h required 0",
                     {busy0, done0, bus0.issue_valid, bus0.addr_a, bus0.addr_b});
        end
        rst_n = 1'b1;
        start = 1'b0;
        start0 = 1'b0;
        tick();
        n_cmp++;
        if ({busy, bus.issue_valid, done_cnt != 0} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_stays_idle: busy=%b valid=%b done_cnt=%0d required 0/0/0",
                     busy, bus.issue_valid, done_cnt);
        end
    endtask

    task automatic test_full_run();
        bit seen;
        clear_mon();
        bus.issue_ready = 1'b1;
        do_start();
        n_cmp++;
        if ({busy, bus.issue_valid, bus.addr_a, bus.addr_b} !== {1'b1, 1'b1, 3'd0, 3'd1}) begin
            n_err++;
            $display("FAIL first_issue: busy=%b valid=%b a=%0d b=%0d required 1 1 0 1",
                     busy, bus.issue_valid, bus.addr_a, bus.addr_b);
        end
        wait_done(60, seen);
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL full_done_seen: got no done within 60 cycles, required a pulse");
        end
        n_cmp++;
        if (xq.size() != 12) begin
            n_err++;
            $display("FAIL full_xfer_count: got %0d required 12", xq.size());
        end
        for (int i = 0; i < 12 && i < xq.size(); i++) begin
            n_cmp++;
            if (xq[i] !== exp_pl(i)) begin
                n_err++;
                $display("FAIL full_xfer_%0d: got %h required %h", i, xq[i], exp_pl(i));
            end
        end
        n_cmp++;
        if (done_cyc - first_cyc + 1 != 19) begin
            n_err++;
            $display("FAIL full_latency: got %0d required 19", done_cyc - first_cyc + 1);
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL busy_after_done: busy=%b done=%b required 0 0", busy, done);
        end
        tick();
        tick();
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL done_pulse_width: got %0d done cycles required 1", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int stalls = 0;
        int presented = 0;
        clear_mon();
        do_start();
        for (int i = 0; i < 80 && done_cnt == 0; i++) begin
            if (bus.issue_valid === 1'b1 && bus.stage_idx == 2'd1 && bus.addr_a == 3'd1) begin
                presented++;
                bus.issue_ready = (stalls >= 3);
                if (stalls < 3) stalls++;
            end else begin
                bus.issue_ready = 1'b1;
            end
            tick();
        end
        bus.issue_ready = 1'b1;
        n_cmp++;
        if (presented != 4) begin
            n_err++;
            $display("FAIL bp_held_cycles: got %0d required 4", presented);
        end
        n_cmp++;
        if (hold_err != 0) begin
            n_err++;
            $display("FAIL bp_hold_stable: got %0d violations required 0", hold_err);
        end
        n_cmp++;
        if (xq.size() != 12) begin
            n_err++;
            $display("FAIL bp_xfer_count: got %0d required 12", xq.size());
        end
        for (int i = 0; i < 12 && i < xq.size(); i++) begin
            n_cmp++;
            if (xq[i] !== exp_pl(i)) begin
                n_err++;
                $display("FAIL bp_xfer_%0d: got %h required %h", i, xq[i], exp_pl(i));
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc - first_cyc + 1 != 22) begin
            n_err++;
            $display("FAIL bp_latency: got %0d (done_cnt %0d) required 22",
                     done_cyc - first_cyc + 1, done_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        bit poked = 1'b0;
        clear_mon();
        do_start();
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            if (!poked && bus.stage_idx == 2'd1 && bus.addr_a == 3'd1) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (xq.size() != 12) begin
            n_err++;
            $display("FAIL sb_xfer_count: got %0d required 12", xq.size());
        end
        for (int i = 0; i < 12 && i < xq.size(); i++) begin
            n_cmp++;
            if (xq[i] !== exp_pl(i)) begin
                n_err++;
                $display("FAIL sb_xfer_%0d: got %h required %h", i, xq[i], exp_pl(i));
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc - first_cyc + 1 != 19 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_timing: latency %0d done_cnt %0d busy %b required 19 1 0",
                     done_cyc - first_cyc + 1, done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        bit hit = 1'b0;
        clear_mon();
        do_start();
        for (int i = 0; i < 40; i++) begin
            if (bus.issue_valid === 1'b1 && bus.stage_idx == 2'd1 && bus.addr_a == 3'd4) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL mid_reach_k2: got no stage1 k=2 issue within 40 cycles, required one");
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({busy, done, bus.issue_valid, bus.last_bfly, pl} !== 15'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {busy, done, bus.issue_valid, bus.last_bfly, pl});
        end
        repeat (25) tick();
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_no_done: done_cnt=%0d busy=%b required 0 0", done_cnt, busy);
        end
        clear_mon();
        do_start();
        wait_done(60, seen);
        n_cmp++;
        if (!seen || xq.size() != 12 || done_cyc - first_cyc + 1 != 19) begin
            n_err++;
            $display("FAIL restart_run: seen=%b xfers=%0d latency=%0d required 1 12 19",
                     seen, xq.size(), done_cyc - first_cyc + 1);
        end
        for (int i = 0; i < 12 && i < xq.size(); i++) begin
            n_cmp++;
            if (xq[i] !== exp_pl(i)) begin
                n_err++;
                $display("FAIL restart_xfer_%0d: got %h required %h", i, xq[i], exp_pl(i));
            end
        end
    endtask

    task automatic test_pipe0();
        logic [7:0] obs;
        bus0.issue_ready = 1'b1;
        start0 = 1'b1;
`ifdef FFT_INVERSE_EN
        inverse0 = 1'b1;
`endif
        tick();
        start0 = 1'b0;
`ifdef FFT_INVERSE_EN
        inverse0 = 1'b0;
`endif
        for (int c = 0; c < 4; c++) begin
            obs = {bus0.issue_valid, bus0.addr_a, bus0.addr_b, bus0.tw_idx, bus0.stage_idx,
                   bus0.last_bfly};
            n_cmp++;
            if (obs !== p0_exp[c]) begin
                n_err++;
                $display("FAIL p0_issue_%0d: got %b required %b", c, obs, p0_exp[c]);
            end
            tick();
        end
        n_cmp++;
        if ({busy0, done0, bus0.issue_valid} !== 3'b110) begin
            n_err++;
            $display("FAIL p0_done_cycle5: busy=%b done=%b valid=%b required 1 1 0",
                     busy0, done0, bus0.issue_valid);
        end
`ifdef FFT_INVERSE_EN
        n_cmp++;
        if (tw_conj0 !== 1'b1) begin
            n_err++;
            $display("FAIL p0_tw_conj_done: got %b required 1", tw_conj0);
        end
`endif
        tick();
        n_cmp++;
        if ({busy0, done0} !== 2'b00) begin
            n_err++;
            $display("FAIL p0_after_done: busy=%b done=%b required 0 0", busy0, done0);
        end
`ifdef FFT_INVERSE_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (tw_conj0 !== 1'b0) begin
            n_err++;
            $display("FAIL p0_tw_conj_reset: got %b required 0", tw_conj0);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        bus.issue_ready = 1'b1;
        bus0.issue_ready = 1'b1;
`ifdef FFT_INVERSE_EN
        inverse = 1'b0;
        inverse0 = 1'b0;
`endif
        clear_mon();
        test_reset();
        test_full_run();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_run();
        test_pipe0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
